// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// The master side is the execute stage together with the data memory it fronts.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_rw;
    logic [31:0] mem_dout;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_din, mem_rw,
        output mem_dout
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_din, mem_rw,
        input  mem_dout
    );
endinterface

// File: rtl/load_store_unit.sv
// MIPS memory-access stage: one outstanding load/store, sub-word stores done as
// read-modify-write against a 256-word memory with a registered read port.
module load_store_unit (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [9:0]  addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merge_val;
    logic        unused_addr_hi;

    // Upper address bits alias onto the 1 KB window.
    assign unused_addr_hi = ^bus.req_addr[31:10];

    assign accept  = bus.req_valid && (state == IDLE);
    assign req_err = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.mem_rw     = 1'b1;
        bus.mem_din    = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (bus.req_write && bus.req_size == 2'b10)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ:  state_nxt = DATA;
            DATA:  state_nxt = write_q ? WRITE : RESP;
            WRITE: begin
                bus.mem_rw  = 1'b0;
                bus.mem_din = (size_q == 2'b10) ? wdata_q : wbuf;
                state_nxt   = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Little-endian lane select for loads and lane merge for sub-word stores.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = bus.mem_dout[7:0];
            2'd1:    byte_lane = bus.mem_dout[15:8];
            2'd2:    byte_lane = bus.mem_dout[23:16];
            default: byte_lane = bus.mem_dout[31:24];
        endcase
        half_lane = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];

        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_val = bus.mem_dout;
        endcase

        merge_val = bus.mem_dout;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merge_val[7:0]   = wdata_q[7:0];
                2'd1:    merge_val[15:8]  = wdata_q[7:0];
                2'd2:    merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[31:16] = wdata_q[15:0];
        end else begin
            merge_val[15:0] = wdata_q[15:0];
        end
    end

    // rdata is cleared when a store or error response is produced, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wbuf     <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= bus.req_addr[9:0];
                size_q   <= bus.req_size;
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                err_q    <= req_err;
                wdata_q  <= bus.req_wdata;
                if (req_err)
                    rdata_q <= '0;
            end
            if (state == DATA) begin
                if (write_q)
                    wbuf <= merge_val;
                else
                    rdata_q <= load_val;
            end
            if (state == WRITE)
                rdata_q <= '0;
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = {24'b0, addr_q[9:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single requests plus
// hand-written sequences for idle, back-to-back and mid-operation reset.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Data memory model: synchronous write when R_W=0, registered read port.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    int          write_count = 0;

    always @(posedge clk) begin
        if (!bus.mem_rw) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_din;
            write_count++;
        end
        bus.mem_dout <= mem[bus.mem_addr[7:0]];
    end

    int cycle = 0;
    int n_acc = 0;
    int acc_cycle [0:63];

    always @(posedge clk) begin
        if (bus.req_valid && bus.req_ready) begin
            if (n_acc < 64)
                acc_cycle[n_acc] = cycle;
            n_acc++;
        end
        cycle++;
    end

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_writes;
        int          row;
        logic [31:0] exp_row;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string n, logic wr, logic [1:0] sz, logic sg,
                                logic [31:0] a, logic [31:0] wd, logic e,
                                logic [31:0] rd, int lat, int nw, int row,
                                logic [31:0] rv);
        vec_t v;
        v.name = n; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = wd;
        v.exp_err = e; v.exp_rdata = rd; v.exp_lat = lat; v.exp_writes = nw;
        v.row = row; v.exp_row = rv;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] a,
                                 input logic [31:0] wd);
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        int lat = 0;
        int w0  = write_count;
        applyStimulus(v.wr, v.sz, v.sg, v.addr, v.wdata);
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({v.name, "_resp_err"}, {31'b0, bus.resp_err}, {31'b0, v.exp_err});
        checkOutput({v.name, "_resp_rdata"}, bus.resp_rdata, v.exp_rdata);
        @(negedge clk);
        checkOutput({v.name, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
        checkOutput({v.name, "_rdata_hold"}, bus.resp_rdata, v.exp_rdata);
        checkOutput({v.name, "_writes"}, 32'(write_count - w0), 32'(v.exp_writes));
        if (v.row >= 0)
            checkOutput({v.name, "_row"}, mem[v.row], v.exp_row);
    endtask

    vec_t vecs [$];

    initial begin
        int bad_rw;
        int w0;
        int base;
        int guard;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        vecs.push_back(mk("ws_10",    1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1, 1, 4, 32'hDEADBEEF));
        vecs.push_back(mk("wl_10",    0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0, 4, 32'hDEADBEEF));
        vecs.push_back(mk("bs_12",    1, 2'b00, 0, 32'h12, 32'hABCDEF5A, 0, 32'h0,        3, 1, 4, 32'hDE5ABEEF));
        vecs.push_back(mk("bs_13",    1, 2'b00, 0, 32'h13, 32'h00000080, 0, 32'h0,        3, 1, 4, 32'h805ABEEF));
        vecs.push_back(mk("blS_13",   0, 2'b00, 1, 32'h13, 32'h0,        0, 32'hFFFFFF80, 2, 0, 4, 32'h805ABEEF));
        vecs.push_back(mk("blU_13",   0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000080, 2, 0, -1, 32'h0));
        vecs.push_back(mk("ws_14",    1, 2'b10, 0, 32'h14, 32'h12345678, 0, 32'h0,        1, 1, 5, 32'h12345678));
        vecs.push_back(mk("hs_16",    1, 2'b01, 0, 32'h16, 32'hFFFF8001, 0, 32'h0,        3, 1, 5, 32'h80015678));
        vecs.push_back(mk("hlS_16",   0, 2'b01, 1, 32'h16, 32'h0,        0, 32'hFFFF8001, 2, 0, -1, 32'h0));
        vecs.push_back(mk("hlU_16",   0, 2'b01, 0, 32'h16, 32'h0,        0, 32'h00008001, 2, 0, -1, 32'h0));
        vecs.push_back(mk("err_hl11", 0, 2'b01, 1, 32'h11, 32'h0,        1, 32'h0,        0, 0, 4, 32'h805ABEEF));
        vecs.push_back(mk("err_ws12", 1, 2'b10, 0, 32'h12, 32'h11111111, 1, 32'h0,        0, 0, 4, 32'h805ABEEF));
        vecs.push_back(mk("err_sz3",  1, 2'b11, 0, 32'h10, 32'h22222222, 1, 32'h0,        0, 0, 4, 32'h805ABEEF));
        vecs.push_back(mk("blU_12",   0, 2'b00, 0, 32'h12, 32'h0,        0, 32'h0000005A, 2, 0, -1, 32'h0));
        vecs.push_back(mk("wl_alias", 0, 2'b10, 0, 32'hFFFFFC10, 32'h0,  0, 32'h805ABEEF, 2, 0, -1, 32'h0));
        vecs.push_back(mk("hs_14",    1, 2'b01, 0, 32'h14, 32'h1234BEEF, 0, 32'h0,        3, 1, 5, 32'h8001BEEF));
        vecs.push_back(mk("hlS_14",   0, 2'b01, 1, 32'h14, 32'h0,        0, 32'hFFFFBEEF, 2, 0, -1, 32'h0));
        vecs.push_back(mk("blS_10",   0, 2'b00, 1, 32'h10, 32'h0,        0, 32'hFFFFFFEF, 2, 0, -1, 32'h0));
        vecs.push_back(mk("ws_20",    1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 32'h0,        1, 1, 8, 32'hCAFEF00D));

        // Reset state, observed while reset is held.
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
        checkOutput("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        checkOutput("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata,          32'd0);
        checkOutput("rst_mem_rw",     {31'b0, bus.mem_rw},     32'd1);
        checkOutput("rst_mem_addr",   bus.mem_addr,            32'd0);
        checkOutput("rst_mem_din",    bus.mem_din,             32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            runVector(vecs[i]);

        // Idle cycles: R_W must stay at read and nothing may be written.
        bad_rw = 0;
        w0 = write_count;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_rw !== 1'b1)
                bad_rw++;
        end
        checkOutput("idle_rw_low_cycles", 32'(bad_rw), 32'd0);
        checkOutput("idle_writes", 32'(write_count - w0), 32'd0);

        // req_valid held through a load: next accept exactly 4 cycles later.
        base = n_acc;
        @(negedge clk);
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_valid  = 1'b1;
        guard = 0;
        while (n_acc < base + 2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid = 1'b0;
        checkOutput("held_accepts", 32'(n_acc - base), 32'd2);
        if (n_acc >= base + 2)
            checkOutput("held_accept_gap", 32'(acc_cycle[base + 1] - acc_cycle[base]), 32'd4);
        repeat (5) @(negedge clk);
        checkOutput("held_ready_after", {31'b0, bus.req_ready}, 32'd1);

        // Byte store aborted by reset while in DATA.
        w0 = write_count;
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000011);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_rw",    {31'b0, bus.mem_rw},    32'd1);
        checkOutput("abort_req_ready", {31'b0, bus.req_ready}, 32'd1);
        bad_rw = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.mem_rw !== 1'b1 || bus.req_ready !== 1'b1)
                bad_rw++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0)
                bad_rw++;
        end
        checkOutput("abort_bad_cycles", 32'(bad_rw), 32'd0);
        checkOutput("abort_writes", 32'(write_count - w0), 32'd0);
        checkOutput("abort_row8", mem[8], 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
